pipelined_acc_param: RTL and testbench
======================================

# pipelined_acc_param

Parametrised successor to the team's fixed 32-bit high-speed accumulator for iCE40 targets. It accumulates A + B into a running total each valid beat. The accumulator loop holds the total in carry-save form, so the loop's critical path has no carry chain. A CHUNK-bit-per-stage funnel pipeline then resolves the total into binary. This generation adds configurable width and chunk size, a valid handshake, and a synchronous restart (clear).

## Interface
- WIDTH, 32: operand and accumulator width in bits. Legal when WIDTH >= CHUNK.
- CHUNK, 4: bits resolved per funnel stage. WIDTH % CHUNK must be 0. N = WIDTH/CHUNK stages.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  A/B/clear are a beat this cycle.
- clear  in  1  restart accumulation at this beat. Honoured even when in_valid=0.
- A  in  WIDTH  operand.
- B  in  WIDTH  operand.
- out_valid  out  1  final_acc carries a resolved beat.
- out_clr  out  1  the emitted beat was a clear beat.
- final_acc  out  WIDTH  running sum mod 2^WIDTH.

## Operation
- Stage 0 (input regs): samples A, B, in_valid and clear every cycle, with no enable.
- Accumulator (acc_s, acc_c), updated from the stage-0 registers:
  - valid and not clear: 4:2 CSA of Ar, Br, acc_s, acc_c. Carry vectors shift left by 1 with bit 0 = 0. Bits shifted past WIDTH-1 are discarded.
  - valid and clear: acc_s, acc_c computed as if the prior acc_s = acc_c = 0, so the result is A+B.
  - not valid and clear: acc_s = acc_c = 0. No output beat is produced.
  - not valid and not clear: hold.
- Funnel stages 1..N:
  - Stage k adds chunk k-1 of the sum/carry pair plus the carry-in from stage k-1, producing CHUNK result bits and a carry.
  - Stage k forwards the remaining upper chunks and delays the lower resolved bits, so the layout matches the fixed design.
  - Carry out of stage N is discarded.
  - The funnel runs every cycle. It has no stall or backpressure.
- valid/clr tags travel alongside the data through every stage, so out_valid and out_clr stay aligned with final_acc.
- Invariant: on an out_valid cycle, final_acc = (sum of A+B over all valid beats since the most recent clear or reset, including this beat) mod 2^WIDTH.
- Non-valid cycles may present stale data on final_acc. Consumers qualify with out_valid.
- N = 1 is legal: stage 1 produces final_acc directly.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system): every register clears immediately.
  - Values after reset: final_acc = 0, out_valid = 0, out_clr = 0, acc = 0, all in-flight tags = 0.
  - The first edge after release already samples inputs.
- Latency: a beat sampled at edge e drives outputs after edge e+N+1, i.e. N+2 register stages. For WIDTH=32, CHUNK=4 that is edge e+9.
- Throughput: one beat per cycle. Back-to-back beats emerge on consecutive cycles.
- The out_valid pattern equals the in_valid pattern delayed by N+1 cycles.
- Reset mid-operation:
  - In-flight beats are dropped, and no out_valid pulse follows release.
  - Accumulation restarts from 0.
- Critical path targets:
  - Accumulator loop: two LUT levels.
  - Funnel stage: one CHUNK-bit carry chain plus carry-in.

## Test plan
- Basic beat: reset, then beat {valid=1, clear=1, A=5, B=7} at edge e -> out_valid=1, out_clr=1, final_acc=12 after edge e+9 only, with out_valid=0 before and after.
- Full-width carry: back-to-back beats {clear, A=0xFFFFFFFF, B=1}, then {A=1, B=0}, then {A=0x7FFFFFFF, B=0x7FFFFFFF} -> consecutive outputs 0x00000000, 0x00000001, 0xFFFFFFFF.
- Bubbles: valid pattern 1,0,0,1,1,0,1 with A=1, B=2 and clear on the first beat -> out_valid pattern identical, delayed 9 cycles. Values 3, 6, 9, 12.
- Clear mid-stream:
  - Accumulate 100 over 4 beats, then send beat {clear, A=10, B=0} -> out_clr=1, final_acc=10, and the next beat {A=1, B=1} gives 12.
  - Repeat with an idle clear (valid=0) -> no output pulse, and the next beat {A=3, B=4} gives 7.
- Reset in flight: 3 valid beats issued, reset asserted 4 cycles later for 2 cycles -> final_acc=0 and out_valid=0 immediately. No valid output after release. Next beat {A=2, B=2} without clear gives 4.
- Parameters: WIDTH=16, CHUNK=8 (N=2) -> beat {clear, A=0x00FF, B=0x0001} at edge e gives final_acc=0x0100 after edge e+3. Repeat the random-stream model check at WIDTH=8, CHUNK=8 (N=1).

Source files
------------

// File: rtl/pipelined_acc_param.sv
// -----------------------------------------------------------------------------
// pipelined_acc_param
//
// Running accumulator of A + B with a carry-save feedback loop and a funnel
// pipeline that resolves the carry-save total into binary, CHUNK bits per
// stage. The accumulator loop contains no carry chain. Each funnel stage
// contains one CHUNK-bit carry chain plus a carry-in.
//
// Parameters
//   WIDTH : operand / accumulator width. Must be >= CHUNK.
//   CHUNK : bits resolved per funnel stage. WIDTH must be a multiple of CHUNK.
//           N = WIDTH / CHUNK funnel stages. N = 1 is legal.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset (clears every register)
//   in_valid  in   A/B/clear form a beat this cycle
//   clear     in   restart accumulation at this beat (honoured when in_valid=0)
//   A, B      in   WIDTH-bit operands
//   out_valid out  final_acc carries a resolved beat
//   out_clr   out  the emitted beat was a clear beat
//   final_acc out  running sum mod 2^WIDTH
//
// Latency: a beat sampled at edge e appears after edge e+N+1.
// -----------------------------------------------------------------------------
module pipelined_acc_param #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             clear,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic             out_clr,
   output logic [WIDTH-1:0] final_acc
);

   localparam int N = WIDTH / CHUNK;

   // 4:2 compressor built from two 3:2 layers. Returns {sum, carry}; the
   // carry vectors are shifted left by one and the bit leaving the MSB is
   // dropped, which is exactly arithmetic mod 2^WIDTH.
   function automatic logic [2*WIDTH-1:0] csa42(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [WIDTH-1:0] s,
      input logic [WIDTH-1:0] c
   );
      logic [WIDTH-1:0] s1, c1, s2, c2;
      s1 = a ^ b ^ s;
      c1 = ((a & b) | (a & s) | (b & s)) << 1;
      s2 = s1 ^ c ^ c1;
      c2 = ((s1 & c) | (s1 & c1) | (c & c1)) << 1;
      return {s2, c2};
   endfunction

   // ---- stage 0: input registers, sampled every cycle ----
   logic [WIDTH-1:0] a_p0, b_p0;
   logic             vld_p0, clr_p0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_p0   <= '0;
         b_p0   <= '0;
         vld_p0 <= 1'b0;
         clr_p0 <= 1'b0;
      end else begin
         a_p0   <= A;
         b_p0   <= B;
         vld_p0 <= in_valid;
         clr_p0 <= clear;
      end
   end

   // ---- stage 1: carry-save accumulator loop ----
   logic [WIDTH-1:0]   acc_s_p1, acc_c_p1;
   logic               vld_p1, clr_p1;
   logic [WIDTH-1:0]   base_s, base_c;
   logic [2*WIDTH-1:0] csa_out;

   // A clear beat compresses against zero, so its result is A+B alone.
   assign base_s  = clr_p0 ? '0 : acc_s_p1;
   assign base_c  = clr_p0 ? '0 : acc_c_p1;
   assign csa_out = csa42(a_p0, b_p0, base_s, base_c);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_s_p1 <= '0;
         acc_c_p1 <= '0;
         vld_p1   <= 1'b0;
         clr_p1   <= 1'b0;
      end else begin
         if (vld_p0) begin
            acc_s_p1 <= csa_out[2*WIDTH-1:WIDTH];
            acc_c_p1 <= csa_out[WIDTH-1:0];
         end else if (clr_p0) begin
            acc_s_p1 <= '0;
            acc_c_p1 <= '0;
         end
         vld_p1 <= vld_p0;
         // An idle clear only zeroes the loop; it never becomes an output beat.
         clr_p1 <= vld_p0 & clr_p0;
      end
   end

   // ---- stages 2..N+1: carry-resolving funnel ----
   // Funnel stage j resolves chunk j. The sum/carry pair is forwarded whole;
   // chunks already resolved are never read again downstream.
   logic [WIDTH-1:0] stg_s_p  [0:N-1];
   logic [WIDTH-1:0] stg_c_p  [0:N-1];
   logic [WIDTH-1:0] stg_r_p  [0:N-1];
   logic             stg_cy_p [0:N-1];
   logic             stg_v_p  [0:N-1];
   logic             stg_k_p  [0:N-1];

   logic [WIDTH-1:0] src_s  [0:N-1];
   logic [WIDTH-1:0] src_c  [0:N-1];
   logic [WIDTH-1:0] src_r  [0:N-1];
   logic             src_cy [0:N-1];
   logic             src_v  [0:N-1];
   logic             src_k  [0:N-1];
   logic [WIDTH-1:0] nxt_r  [0:N-1];
   logic             nxt_cy [0:N-1];
   logic [CHUNK:0]   csum   [0:N-1];

   always_comb begin
      src_s[0]  = acc_s_p1;
      src_c[0]  = acc_c_p1;
      src_r[0]  = '0;
      src_cy[0] = 1'b0;
      src_v[0]  = vld_p1;
      src_k[0]  = clr_p1;
      for (int j = 1; j < N; j++) begin
         src_s[j]  = stg_s_p[j-1];
         src_c[j]  = stg_c_p[j-1];
         src_r[j]  = stg_r_p[j-1];
         src_cy[j] = stg_cy_p[j-1];
         src_v[j]  = stg_v_p[j-1];
         src_k[j]  = stg_k_p[j-1];
      end
      for (int j = 0; j < N; j++) begin
         csum[j] = {1'b0, src_s[j][j*CHUNK +: CHUNK]}
                 + {1'b0, src_c[j][j*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_cy[j]};
         nxt_r[j] = src_r[j];
         nxt_r[j][j*CHUNK +: CHUNK] = csum[j][CHUNK-1:0];
         nxt_cy[j] = csum[j][CHUNK];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < N; j++) begin
            stg_s_p[j]  <= '0;
            stg_c_p[j]  <= '0;
            stg_r_p[j]  <= '0;
            stg_cy_p[j] <= 1'b0;
            stg_v_p[j]  <= 1'b0;
            stg_k_p[j]  <= 1'b0;
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            stg_s_p[j]  <= src_s[j];
            stg_c_p[j]  <= src_c[j];
            stg_r_p[j]  <= nxt_r[j];
            stg_cy_p[j] <= nxt_cy[j];
            stg_v_p[j]  <= src_v[j];
            stg_k_p[j]  <= src_k[j];
         end
      end
   end

   // The carry out of the last stage wraps the total mod 2^WIDTH.
   assign final_acc = stg_r_p[N-1];
   assign out_valid = stg_v_p[N-1];
   assign out_clr   = stg_k_p[N-1];

endmodule

// File: tb/tb_pipelined_acc_param.sv
module tb_pipelined_acc_param;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // 32/4 instance (N = 8, latency 9 edges after the sampling edge)
   logic        v32 = 0, c32 = 0;
   logic [31:0] a32 = 0, b32 = 0;
   logic        ov32, oc32;
   logic [31:0] fa32;

   // 16/8 instance (N = 2, latency 3)
   logic        v16 = 0, c16 = 0;
   logic [15:0] a16 = 0, b16 = 0;
   logic        ov16, oc16;
   logic [15:0] fa16;

   // 8/8 instance (N = 1, latency 2)
   logic        v8 = 0, c8 = 0;
   logic [7:0]  a8 = 0, b8 = 0;
   logic        ov8, oc8;
   logic [7:0]  fa8;

   pipelined_acc_param #(.WIDTH(32), .CHUNK(4)) dut32 (
      .clk(clk), .reset(reset), .in_valid(v32), .clear(c32), .A(a32), .B(b32),
      .out_valid(ov32), .out_clr(oc32), .final_acc(fa32));

   pipelined_acc_param #(.WIDTH(16), .CHUNK(8)) dut16 (
      .clk(clk), .reset(reset), .in_valid(v16), .clear(c16), .A(a16), .B(b16),
      .out_valid(ov16), .out_clr(oc16), .final_acc(fa16));

   pipelined_acc_param #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .clear(c8), .A(a8), .B(b8),
      .out_valid(ov8), .out_clr(oc8), .final_acc(fa8));

   // Expectation delay lines: index 0 is the beat about to be sampled,
   // index LAT is the beat due at the outputs after the edge.
   logic        e32v [0:9];
   logic        e32c [0:9];
   logic [31:0] e32d [0:9];
   logic        e16v [0:3];
   logic        e16c [0:3];
   logic [15:0] e16d [0:3];
   logic        e8v  [0:2];
   logic        e8c  [0:2];
   logic [7:0]  e8d  [0:2];

   logic        cur32v = 0, cur32c = 0;
   logic [31:0] cur32d = 0;
   logic        cur16v = 0, cur16c = 0;
   logic [15:0] cur16d = 0;
   logic        cur8v = 0, cur8c = 0;
   logic [7:0]  cur8d = 0;
   logic [7:0]  acc8 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 10; i++) begin e32v[i] = 0; e32c[i] = 0; e32d[i] = 0; end
      for (int i = 0; i < 4; i++)  begin e16v[i] = 0; e16c[i] = 0; e16d[i] = 0; end
      for (int i = 0; i < 3; i++)  begin e8v[i] = 0;  e8c[i] = 0;  e8d[i] = 0;  end
      acc8 = 0;
   endtask

   // One clock: push the current expectations, take the edge, check outputs.
   task automatic tick();
      for (int i = 9; i > 0; i--) begin e32v[i] = e32v[i-1]; e32c[i] = e32c[i-1]; e32d[i] = e32d[i-1]; end
      for (int i = 3; i > 0; i--) begin e16v[i] = e16v[i-1]; e16c[i] = e16c[i-1]; e16d[i] = e16d[i-1]; end
      for (int i = 2; i > 0; i--) begin e8v[i]  = e8v[i-1];  e8c[i]  = e8c[i-1];  e8d[i]  = e8d[i-1];  end
      e32v[0] = reset & cur32v; e32c[0] = reset & cur32v & cur32c; e32d[0] = cur32d;
      e16v[0] = reset & cur16v; e16c[0] = reset & cur16v & cur16c; e16d[0] = cur16d;
      e8v[0]  = reset & cur8v;  e8c[0]  = reset & cur8v & cur8c;   e8d[0]  = cur8d;
      @(posedge clk);
      #1;
      check("out_valid32", {31'b0, ov32}, {31'b0, e32v[9]});
      if (e32v[9]) begin
         check("final_acc32", fa32, e32d[9]);
         check("out_clr32", {31'b0, oc32}, {31'b0, e32c[9]});
      end
      check("out_valid16", {31'b0, ov16}, {31'b0, e16v[3]});
      if (e16v[3]) begin
         check("final_acc16", {16'b0, fa16}, {16'b0, e16d[3]});
         check("out_clr16", {31'b0, oc16}, {31'b0, e16c[3]});
      end
      check("out_valid8", {31'b0, ov8}, {31'b0, e8v[2]});
      if (e8v[2]) begin
         check("final_acc8", {24'b0, fa8}, {24'b0, e8d[2]});
         check("out_clr8", {31'b0, oc8}, {31'b0, e8c[2]});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic beat(input logic v, input logic c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
      v32 = v; c32 = c; a32 = a; b32 = b;
      cur32v = v; cur32c = c; cur32d = e;
      tick();
      v32 = 0; c32 = 0; a32 = 32'hDEAD_BEEF; b32 = 32'h1357_9BDF;
      cur32v = 0; cur32c = 0;
   endtask

   task automatic beat16(input logic v, input logic c, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] e);
      v16 = v; c16 = c; a16 = a; b16 = b;
      cur16v = v; cur16c = c; cur16d = e;
      tick();
      v16 = 0; c16 = 0; a16 = 16'hA5A5; b16 = 16'h5A5A;
      cur16v = 0; cur16c = 0;
   endtask

   // Reset asserted between edges while beats are in flight.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_final_acc32", fa32, 32'h0);
      check("rst_out_valid32", {31'b0, ov32}, 32'h0);
      check("rst_out_clr32", {31'b0, oc32}, 32'h0);
      check("rst_out_valid16", {31'b0, ov16}, 32'h0);
      flush();
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      flush();
      // Reset state
      tick();
      tick();
      check("reset_final_acc32", fa32, 32'h0);
      check("reset_out_clr32", {31'b0, oc32}, 32'h0);
      check("reset_final_acc16", {16'b0, fa16}, 32'h0);
      check("reset_final_acc8", {24'b0, fa8}, 32'h0);
      reset = 1'b1;
      idle(2);

      // Basic beat: 5 + 7 with clear
      beat(1, 1, 32'd5, 32'd7, 32'd12);
      idle(12);

      // Full-width carry propagation, back to back
      beat(1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      beat(1, 0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001);
      beat(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      idle(10);

      // Bubbles: valid pattern 1,0,0,1,1,0,1
      beat(1, 1, 32'd1, 32'd2, 32'd3);
      idle(2);
      beat(1, 0, 32'd1, 32'd2, 32'd6);
      beat(1, 0, 32'd1, 32'd2, 32'd9);
      idle(1);
      beat(1, 0, 32'd1, 32'd2, 32'd12);
      idle(10);

      // Clear mid-stream with a valid beat
      beat(1, 1, 32'd10, 32'd15, 32'd25);
      beat(1, 0, 32'd20, 32'd5,  32'd50);
      beat(1, 0, 32'd30, 32'd0,  32'd80);
      beat(1, 0, 32'd10, 32'd10, 32'd100);
      beat(1, 1, 32'd10, 32'd0,  32'd10);
      beat(1, 0, 32'd1,  32'd1,  32'd12);
      idle(10);

      // Idle clear: no output pulse, accumulation restarts
      beat(1, 0, 32'd50, 32'd50, 32'd112);
      beat(0, 1, 32'd9,  32'd9,  32'd0);
      beat(1, 0, 32'd3,  32'd4,  32'd7);
      idle(10);

      // Reset in flight
      beat(1, 0, 32'd1, 32'd1, 32'd9);
      beat(1, 0, 32'd1, 32'd1, 32'd11);
      beat(1, 0, 32'd1, 32'd1, 32'd13);
      idle(4);
      async_reset();
      idle(12);
      beat(1, 0, 32'd2, 32'd2, 32'd4);
      idle(10);

      // WIDTH=16, CHUNK=8: chunk carry crosses the stage boundary
      beat16(1, 1, 16'h00FF, 16'h0001, 16'h0100);
      beat16(1, 0, 16'h0F0F, 16'h00F1, 16'h1100);
      idle(5);

      // WIDTH=8, CHUNK=8: random stream against a running-sum model
      for (int i = 0; i < 60; i++) begin
         v8 = ($urandom_range(0, 3) != 0);
         c8 = (i == 0) || ($urandom_range(0, 7) == 0);
         a8 = 8'($urandom_range(0, 255));
         b8 = 8'($urandom_range(0, 255));
         if (c8 && !v8)
            acc8 = 8'h00;
         else if (v8)
            acc8 = (c8 ? 8'h00 : acc8) + a8 + b8;
         cur8v = v8; cur8c = c8; cur8d = acc8;
         tick();
      end
      v8 = 0; c8 = 0; cur8v = 0; cur8c = 0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
